// File: rtl/shift_arbiter.sv
// shift_arbiter: two valid/ready requesters share one 32-bit right shifter
// (logical or arithmetic). Grants are round-robin. The accepted operation is
// computed in one CALC cycle and held in a registered result stage until the
// consumer takes it. Per-port completion counters feed debug/display logic.
module shift_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_src0,
  input  logic [4:0]       req0_src1,
  input  logic             req0_arith,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_src0,
  input  logic [4:0]       req1_src1,
  input  logic             req1_arith,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic [31:0] op_src0;
  logic [4:0]  op_src1;
  logic        op_arith;
  logic        op_id;

  logic        grant_id;
  logic        accept;
  logic        res_fire;
  logic [31:0] shift_logical;
  logic [31:0] shift_fill;
  logic [31:0] shift_result;

  // Round-robin grant: a lone requester always wins; on contention the port
  // that did not win last time is chosen.
  // NOTE: every signal driven in always_comb gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready is only offered in IDLE and only to the granted, requesting port.
  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;
  assign res_fire   = res_valid && res_ready;
  assign busy       = (state != IDLE);

  // Shared shifter: logical shift, then OR in sign fill for negative
  // arithmetic operands. Shift by 0 produces an empty fill mask.
  always_comb begin
    shift_logical = op_src0 >> op_src1;
    shift_fill    = ~(32'hFFFF_FFFF >> op_src1);
    shift_result  = shift_logical;
    if (op_arith && op_src0[31]) begin
      shift_result = shift_logical | shift_fill;
    end
  end

  // Next-state logic: IDLE -> CALC on accept, CALC lasts one cycle,
  // DONE waits for the result handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = CALC;
      CALC:                  state_next = DONE;
      DONE:    if (res_fire) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the granted operation and remember who won.
  // NOTE: operand registers are reset to zero so the shifter input is
  // deterministic after reset even though it is only consumed in CALC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_src0    <= '0;
      op_src1    <= '0;
      op_arith   <= 1'b0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_src0    <= grant_id ? req1_src0  : req0_src0;
      op_src1    <= grant_id ? req1_src1  : req0_src1;
      op_arith   <= grant_id ? req1_arith : req0_arith;
      op_id      <= grant_id;
      last_grant <= grant_id;
    end
  end

  // Result stage: load at the end of CALC, hold through DONE, drop valid on
  // the handshake. Data and id keep their last values afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
    end else if (state == CALC) begin
      res_valid <= 1'b1;
      res_data  <= shift_result;
      res_id    <= op_id;
    end else if (res_fire) begin
      res_valid <= 1'b0;
    end
  end

  // Per-port completion counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (res_fire) begin
      if (res_id) begin
        cnt1 <= cnt1 + CNT_W'(1);
      end else begin
        cnt0 <= cnt0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed testbench for shift_arbiter. A second instance with CNT_W=2 is
// driven by the same stimulus to exercise counter wrap.
module tb_shift_arbiter;

  logic        clk;
  logic        rstn;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_src0, req1_src0;
  logic [4:0]  req0_src1, req1_src1;
  logic        req0_arith, req1_arith;
  logic        res_ready;

  logic        req0_ready, req1_ready, res_valid, res_id, busy;
  logic [31:0] res_data;
  logic [15:0] cnt0, cnt1;

  logic        w_req0_ready, w_req1_ready, w_res_valid, w_res_id, w_busy;
  logic [31:0] w_res_data;
  logic [1:0]  w_cnt0, w_cnt1;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt0, exp_cnt1;

  shift_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src0(req0_src0),
    .req0_src1(req0_src1), .req0_arith(req0_arith),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src0(req1_src0),
    .req1_src1(req1_src1), .req1_arith(req1_arith),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  shift_arbiter #(.CNT_W(2)) dut_w (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_src0(req0_src0),
    .req0_src1(req0_src1), .req0_arith(req0_arith),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_src0(req1_src0),
    .req1_src1(req1_src1), .req1_arith(req1_arith),
    .res_valid(w_res_valid), .res_ready(res_ready), .res_data(w_res_data),
    .res_id(w_res_id), .busy(w_busy), .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Hold reset for two edges; release off-edge. Leaves time at posedge+1.
  task automatic do_reset();
    rstn       = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_src0  = '0;   req1_src0  = '0;
    req0_src1  = '0;   req1_src1  = '0;
    req0_arith = 1'b0; req1_arith = 1'b0;
    res_ready  = 1'b1;
    exp_cnt0   = '0;   exp_cnt1   = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Issue one operation on a port with res_ready high and check every stage.
  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic do_op(input logic port, input logic [31:0] a, input logic [4:0] sh,
                       input logic ar, input logic [31:0] exp);
    if (port) begin
      req1_valid = 1'b1; req1_src0 = a; req1_src1 = sh; req1_arith = ar;
    end else begin
      req0_valid = 1'b1; req0_src0 = a; req0_src1 = sh; req0_arith = ar;
    end
    #1;
    check("op_ready", {30'd0, req1_ready, req0_ready}, port ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("op_calc_valid", {31'd0, res_valid}, 32'd0);
    check("op_calc_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("op_res_valid", {31'd0, res_valid}, 32'd1);
    check("op_res_data", res_data, exp);
    check("op_res_id", {31'd0, res_id}, {31'd0, port});
    check("op_w_res_data", w_res_data, exp);
    check("op_w_res_id", {31'd0, w_res_id}, {31'd0, port});
    @(posedge clk); #1;
    if (port) exp_cnt1 = exp_cnt1 + 16'd1;
    else      exp_cnt0 = exp_cnt0 + 16'd1;
    check("op_done_valid", {31'd0, res_valid}, 32'd0);
    check("op_idle_busy", {31'd0, busy}, 32'd0);
    check("op_cnt0", {16'd0, cnt0}, {16'd0, exp_cnt0});
    check("op_cnt1", {16'd0, cnt1}, {16'd0, exp_cnt1});
    check("op_w_cnt0", {30'd0, w_cnt0}, {30'd0, exp_cnt0[1:0]});
    check("op_w_cnt1", {30'd0, w_cnt1}, {30'd0, exp_cnt1[1:0]});
  endtask

  initial begin
    int n_acc;
    int n_res;
    logic [31:0] exp_by_id [2];
    logic [1:0] wrap_seq [5];

    // Reset state
    do_reset();
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_id", {31'd0, res_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cnt", {cnt1, cnt0}, 32'd0);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst_w_state", {29'd0, w_busy, w_req1_ready, w_req0_ready}, 32'd0);

    // Basic operations and shift-amount edge cases
    do_op(1'b0, 32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000);
    do_op(1'b1, 32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000);
    do_op(1'b0, 32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678);
    do_op(1'b1, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
    do_op(1'b0, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    do_op(1'b1, 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000);

    // Continuous contention: alternating grants starting with port 0
    do_reset();
    req0_src0 = 32'hF000_0000; req0_src1 = 5'd4; req0_arith = 1'b1;
    req1_src0 = 32'hF000_0000; req1_src1 = 5'd8; req1_arith = 1'b0;
    exp_by_id[0] = 32'hFF00_0000;
    exp_by_id[1] = 32'h00F0_0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n_acc = 0; n_res = 0;
    for (int cyc = 0; cyc < 40 && n_res < 6; cyc++) begin
      #1;
      if (req0_ready && req1_ready) check("rr_both_ready", 32'd1, 32'd0);
      if (req0_ready || req1_ready) begin
        check("rr_grant", {31'd0, req1_ready}, n_acc % 2);
        n_acc++;
      end
      if (res_valid && res_ready) begin
        check("rr_res_id", {31'd0, res_id}, n_res % 2);
        check("rr_res_data", res_data, exp_by_id[n_res % 2]);
        n_res++;
      end
      if (n_res == 6) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("rr_result_count", n_res, 32'd6);
    check("rr_accept_count", n_acc, 32'd6);
    check("rr_cnt0", {16'd0, cnt0}, 32'd3);
    check("rr_cnt1", {16'd0, cnt1}, 32'd3);
    check("rr_idle", {31'd0, busy}, 32'd0);

    // Backpressure with requests waiting, then handshake and next grant
    do_reset();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_src0 = 32'h1234_5678; req0_src1 = 5'd0; req0_arith = 1'b0;
    @(posedge clk); #1;
    req0_src0 = 32'hAAAA_0000; req0_src1 = 5'd3; req0_arith = 1'b0;
    req1_valid = 1'b1; req1_src0 = 32'h8000_0000; req1_src1 = 5'd31; req1_arith = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_data", res_data, 32'h1234_5678);
      check("bp_id", {31'd0, res_id}, 32'd0);
      check("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    #1;
    check("bp_fire_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;
    check("bp_after_valid", {31'd0, res_valid}, 32'd0);
    check("bp_after_data", res_data, 32'h1234_5678);
    check("bp_after_cnt0", {16'd0, cnt0}, 32'd1);
    check("bp_next_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_p1_data", res_data, 32'hFFFF_FFFF);
    check("bp_p1_id", {31'd0, res_id}, 32'd1);
    @(posedge clk); #1;
    check("bp_p1_cnt1", {16'd0, cnt1}, 32'd1);

    // Asynchronous reset while in CALC
    do_reset();
    do_op(1'b1, 32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F);
    req0_valid = 1'b1; req0_src0 = 32'hDEAD_BEEF; req0_src1 = 5'd1; req0_arith = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("ar_calc_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_valid", {31'd0, res_valid}, 32'd0);
    check("ar_cnt", {cnt1, cnt0}, 32'd0);
    #1 rstn = 1'b1;
    exp_cnt0 = '0; exp_cnt1 = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("ar_no_result", {31'd0, res_valid}, 32'd0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("ar_p0_wins", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    check("ar_drop_idle", {31'd0, busy}, 32'd0);

    // Counter wrap on the two-bit instance
    do_reset();
    wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, 32'hFFFF_0000, 5'd16, 1'b0, 32'h0000_FFFF);
      check("wrap_cnt0", {30'd0, w_cnt0}, {30'd0, wrap_seq[i]});
    end
    check("wrap_wide_cnt0", {16'd0, cnt0}, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
